// File: rtl/load_store_unit_if.sv
// Core-side request/response and RAM-side bus of the load/store unit.
// The slave modport is the unit itself; the master modport is its environment
// (core plus RAM).
interface load_store_unit_if #(
  parameter int unsigned RAM_ADDR_W = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_misaligned;
  logic                  ram_wr_en;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
    input  ram_wr_en, ram_addr, ram_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
    output ram_wr_en, ram_addr, ram_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a single-port word RAM with one cycle of
// read latency. Sub-word stores are done as read-modify-write.
module load_store_unit #(
  parameter int unsigned RAM_ADDR_W = 10
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StRd, StRdWait, StWr, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        misaligned_q;

  logic        accept;
  logic        req_misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        unused_addr;

  assign accept      = bus.req_valid && bus.req_ready;
  // Address bits above the RAM word index are intentionally dropped.
  assign unused_addr = ^addr_q[31:RAM_ADDR_W+2];

  // Alignment / legality decode on the live request.
  always_comb begin
    req_misaligned = 1'b0;
    unique case (bus.req_funct3)
      3'b000:  req_misaligned = 1'b0;
      3'b001:  req_misaligned = bus.req_addr[0];
      3'b010:  req_misaligned = |bus.req_addr[1:0];
      3'b100:  req_misaligned = bus.req_we;
      3'b101:  req_misaligned = bus.req_we || bus.req_addr[0];
      default: req_misaligned = 1'b1;
    endcase
  end

  // Lane select and extension of load data, plus the sub-word store merge.
  always_comb begin
    byte_sel  = bus.ram_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel  = addr_q[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
    load_data = bus.ram_rdata;
    merged    = bus.ram_rdata;
    unique case (funct3_q[1:0])
      2'b00: begin
        load_data = {{24{byte_sel[7] & ~funct3_q[2]}}, byte_sel};
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_data = {{16{half_sel[15] & ~funct3_q[2]}}, half_sel};
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: begin
        load_data = bus.ram_rdata;
        merged    = bus.ram_rdata;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_misaligned) begin
            state_d = StResp;
          end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:     state_d = StRdWait;
      StRdWait: state_d = we_q ? StWr : StResp;
      StWr:     state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State, request latch and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= bus.req_we;
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
      end
      if (state_q == StRdWait && we_q) begin
        wdata_q <= merged;
      end
      // Response fields change only on entry to RESP, so they hold until the next one.
      if (state_d == StResp) begin
        rdata_q      <= (state_q == StRdWait && !we_q) ? load_data : 32'h0;
        misaligned_q <= (state_q == StIdle);
      end
    end
  end

  // Outputs are forced low while reset is asserted.
  always_comb begin
    bus.req_ready       = (state_q == StIdle) && !rst;
    bus.resp_valid      = (state_q == StResp) && !rst;
    bus.ram_wr_en       = (state_q == StWr) && !rst;
    bus.ram_addr        = rst ? '0 : addr_q[RAM_ADDR_W+1:2];
    bus.ram_wdata       = rst ? 32'h0 : wdata_q;
    bus.resp_rdata      = rst ? 32'h0 : rdata_q;
    bus.resp_misaligned = rst ? 1'b0 : misaligned_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases followed by
// random requests, checked against a word-array reference memory.
module tb_load_store_unit;
  localparam int unsigned AW    = 10;
  localparam int unsigned WORDS = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  load_store_unit_if #(.RAM_ADDR_W(AW)) bus ();

  load_store_unit #(.RAM_ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];

  // RAM with one cycle of read latency.
  always @(posedge clk) begin
    bus.ram_rdata <= mem[bus.ram_addr];
    if (bus.ram_wr_en) mem[bus.ram_addr] <= bus.ram_wdata;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input int idx, input logic [31:0] val);
    mem[idx]     <= val;
    ref_mem[idx]  = val;
    #1;
  endtask

  // One request through the unit, checked against the reference rules.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit hold);
    int          idx, off, size, lat, k, wr_cnt, wr_k;
    bit          mis;
    logic [31:0] word, exp_rd, new_word, sh, wr_addr, wr_data;
    logic [63:0] mask;
    idx  = int'((addr >> 2) % WORDS);
    off  = int'(addr % 4);
    size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    mis  = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 >= 3'd4) || (addr % size != 0);
    word     = ref_mem[idx];
    exp_rd   = 32'h0;
    new_word = word;
    if (!mis && !we) begin
      sh = word >> (8 * off);
      if (size == 1) begin
        exp_rd = sh & 32'hFF;
        if (f3 < 3'd4 && exp_rd >= 32'h80) exp_rd = exp_rd | 32'hFFFF_FF00;
      end else if (size == 2) begin
        exp_rd = sh & 32'hFFFF;
        if (f3 < 3'd4 && exp_rd >= 32'h8000) exp_rd = exp_rd | 32'hFFFF_0000;
      end else begin
        exp_rd = word;
      end
    end
    if (!mis && we) begin
      mask     = ((64'd1 << (8 * size)) - 64'd1) << (8 * off);
      new_word = (word & ~mask[31:0]) | ((wdata << (8 * off)) & mask[31:0]);
    end
    lat = mis ? 1 : (!we ? 3 : (size == 4 ? 2 : 4));

    chk("ready_before", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    step();
    k = 1;
    if (!hold) bus.req_valid = 1'b0;
    // Inputs must be ignored after acceptance.
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    wr_cnt  = 0;
    wr_k    = 0;
    wr_addr = 32'h0;
    wr_data = 32'h0;
    while (!bus.resp_valid && k < 8) begin
      if (hold) chk("ready_busy", 32'(bus.req_ready), 32'd0);
      if (bus.ram_wr_en) begin
        wr_cnt++;
        wr_k    = k;
        wr_addr = 32'(bus.ram_addr);
        wr_data = bus.ram_wdata;
      end
      step();
      k++;
    end
    chk("resp_seen", 32'(bus.resp_valid), 32'd1);
    chk("latency", k, lat);
    chk("misaligned", 32'(bus.resp_misaligned), 32'(mis));
    chk("rdata", bus.resp_rdata, exp_rd);
    chk("wr_en_in_resp", 32'(bus.ram_wr_en), 32'd0);
    if (hold) chk("ready_in_resp", 32'(bus.req_ready), 32'd0);
    chk("wr_count", wr_cnt, (!mis && we) ? 1 : 0);
    if (!mis && we) begin
      chk("wr_cycle", wr_k, lat - 1);
      chk("wr_addr", wr_addr, idx);
      chk("wr_data", wr_data, new_word);
      ref_mem[idx] = new_word;
    end
    step();
    chk("ready_idle", 32'(bus.req_ready), 32'd1);
    if (hold) bus.req_valid = 1'b0;
    chk("resp_pulse", 32'(bus.resp_valid), 32'd0);
    chk("rdata_hold", bus.resp_rdata, exp_rd);
    chk("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    logic [31:0] v, a;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    for (int i = 0; i < int'(WORDS); i++) begin
      v          = $urandom;
      mem[i]    <= v;
      ref_mem[i] = v;
    end

    // Reset behaviour, with a request already presented.
    bus.req_valid = 1'b1;
    repeat (3) step();
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_wr_en", 32'(bus.ram_wr_en), 32'd0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_ram_wdata", bus.ram_wdata, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_misaligned", 32'(bus.resp_misaligned), 32'd0);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

    // SW to word 5.
    run_req(1'b1, 3'b010, 32'h14, 32'h0000_0104, 1'b0);
    chk("sw_word5", mem[5], 32'h0000_0104);

    // Loads with sign/zero extension.
    preset(5, 32'h80FF_1234);
    run_req(1'b0, 3'b000, 32'h17, 32'h0, 1'b0);
    run_req(1'b0, 3'b100, 32'h17, 32'h0, 1'b0);
    run_req(1'b0, 3'b001, 32'h16, 32'h0, 1'b0);

    // Read-modify-write byte and halfword stores.
    preset(5, 32'h1122_3344);
    run_req(1'b1, 3'b000, 32'h15, 32'h0000_00AB, 1'b0);
    chk("sb_word5", mem[5], 32'h1122_AB44);
    run_req(1'b1, 3'b001, 32'h16, 32'h0000_BEEF, 1'b0);
    chk("sh_word5", mem[5], 32'hBEEF_AB44);

    // Misaligned requests.
    run_req(1'b0, 3'b010, 32'h16, 32'h0, 1'b0);
    run_req(1'b1, 3'b001, 32'h13, 32'h0000_5555, 1'b0);

    // Reset during the WR cycle of a byte store aborts it.
    preset(5, 32'h1122_3344);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h15;
    bus.req_wdata  = 32'h0000_00AB;
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    chk("abort_in_wr", 32'(bus.ram_wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_wr_en", 32'(bus.ram_wr_en), 32'd0);
    chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_resp", 32'(bus.resp_valid), 32'd0);
      step();
    end
    chk("abort_word5", mem[5], 32'h1122_3344);

    // Address wrap with req_valid held through the transaction.
    run_req(1'b1, 3'b010, 32'h1014, 32'hCAFE_F00D, 1'b1);
    run_req(1'b0, 3'b010, 32'h14, 32'h0, 1'b0);

    // Random traffic.
    for (int n = 0; n < 80; n++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_req(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
